// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, default parameters and access-alignment helper for the
// fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2
    } arb_state_t;

    localparam int DEF_STARVE_LIMIT   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [3:0] wstrb);
        case (wstrb)
            4'b1111:          return (addr_lo != 2'b00);
            4'b0011, 4'b1100: return addr_lo[0];
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Wait-cycle counter: counts stalled memory-port cycles and flags the cycle
// whose edge brings the count to the limit.
module arb_timeout_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic [15:0] i_limit,
    output logic        o_expired
);

    logic [15:0] r_cnt;

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= 16'd0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = i_enable && (r_cnt == (i_limit - 16'd1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port with
// starvation protection, alignment checking and a stall timeout.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic        m_err,
    input  logic [31:0] m_rdata
);

    arb_state_t  r_state, w_state_nxt;
    logic [7:0]  r_starve_cnt;
    logic        r_m_valid, r_m_we, r_if_ack, r_if_err, r_d_ack, r_d_err;
    logic [31:0] r_m_addr, r_m_wdata, r_if_rdata, r_d_rdata;
    logic [3:0]  r_m_wstrb;
    logic        w_grant_d, w_grant_if, w_misalign, w_done, w_expired;
    logic        w_if_eff, w_force_if;

    arb_timeout_counter u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (r_m_valid & ~m_ready),
        .i_clear   (~r_m_valid | m_ready),
        .i_limit   (16'(TIMEOUT_CYCLES)),
        .o_expired (w_expired)
    );

    // Grant decision and next state. In an ack cycle the acked requester's
    // req is still up from the finished transfer: a masked data req still
    // wins priority but is not granted, so fetch only overtakes via starvation.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_if  = 1'b0;
        w_misalign  = is_misaligned(d_addr[1:0], d_wstrb);
        w_done      = r_m_valid & m_ready;
        w_if_eff    = if_req & ~r_if_ack;
        w_force_if  = w_if_eff & (r_starve_cnt == 8'(STARVE_LIMIT));
        case (r_state)
            IDLE: begin
                if (d_req && !w_force_if) begin
                    if (!r_d_ack) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = w_misalign ? IDLE : GRANT_D;
                    end else begin
                        w_grant_d   = 1'b0;
                    end
                end else if (w_if_eff) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = GRANT_IF;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT_IF, GRANT_D: begin
                if (w_done || w_expired) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, request-port and completion registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 8'd0;
            r_m_valid    <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= 32'd0;
            r_m_wdata    <= 32'd0;
            r_m_wstrb    <= 4'd0;
            r_if_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_rdata   <= 32'd0;
            r_d_ack      <= 1'b0;
            r_d_err      <= 1'b0;
            r_d_rdata    <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_if_ack <= 1'b0;
            r_if_err <= 1'b0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
            if (w_grant_d) begin
                if (!w_if_eff) begin
                    r_starve_cnt <= 8'd0;
                end else if (r_starve_cnt != 8'(STARVE_LIMIT)) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end else begin
                    r_starve_cnt <= r_starve_cnt;
                end
                if (w_misalign) begin
                    r_d_ack <= 1'b1;
                    r_d_err <= 1'b1;
                end else begin
                    r_m_valid <= 1'b1;
                    r_m_we    <= d_we;
                    r_m_addr  <= d_addr;
                    r_m_wdata <= d_wdata;
                    r_m_wstrb <= d_wstrb;
                end
            end else if (w_grant_if) begin
                r_starve_cnt <= 8'd0;
                r_m_valid    <= 1'b1;
                r_m_we       <= 1'b0;
                r_m_addr     <= if_addr;
                r_m_wstrb    <= 4'd0;
            end else if (w_done || w_expired) begin
                r_m_valid <= 1'b0;
                if (r_state == GRANT_IF) begin
                    r_if_ack   <= 1'b1;
                    r_if_err   <= w_done ? m_err : 1'b1;
                    r_if_rdata <= w_done ? m_rdata : 32'd0;
                end else begin
                    r_d_ack    <= 1'b1;
                    r_d_err    <= w_done ? m_err : 1'b1;
                    r_d_rdata  <= w_done ? m_rdata : 32'd0;
                end
            end else begin
                r_m_valid <= r_m_valid;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_wstrb  = r_m_wstrb;
    assign if_ack   = r_if_ack;
    assign if_err   = r_if_err;
    assign if_rdata = r_if_rdata;
    assign d_ack    = r_d_ack;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES=8,
// STARVE_LIMIT=4). Inputs change and outputs are sampled 1ns after posedge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, m_ready, m_err;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, if_err, d_ack, d_err, m_valid, m_we;
    logic [3:0]  m_wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        int n_d_before_if;
        logic seen_if;
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0; m_err = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; m_rdata = 32'd0;
        step(); step();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_acks", {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wstrb_we", {27'd0, m_wstrb, m_we}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        step();

        // Simultaneous requests: data first, fetch right after the data ack.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010; d_wstrb = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0200; m_ready = 1'b1; m_rdata = 32'h1111_2222;
        step();
        chk("sim_c1_m_valid", {31'd0, m_valid}, 32'd1);
        chk("sim_c1_m_addr", m_addr, 32'h0000_0010);
        step();
        chk("sim_c2_d_ack", {31'd0, d_ack}, 32'd1);
        chk("sim_c2_d_rdata", d_rdata, 32'h1111_2222);
        chk("sim_c2_m_valid", {31'd0, m_valid}, 32'd0);
        d_req = 1'b0; m_rdata = 32'h3333_4444;
        step();
        chk("sim_c3_m_valid", {31'd0, m_valid}, 32'd1);
        chk("sim_c3_m_addr", m_addr, 32'h0000_0200);
        chk("sim_c3_fetch_we_strb", {27'd0, m_wstrb, m_we}, 32'd0);
        chk("sim_c3_d_ack_pulse", {31'd0, d_ack}, 32'd0);
        step();
        chk("sim_c4_if_ack", {30'd0, if_ack, if_err}, 32'd2);
        chk("sim_c4_if_rdata", if_rdata, 32'h3333_4444);
        if_req = 1'b0;
        step();
        chk("sim_c5_if_ack_pulse", {31'd0, if_ack}, 32'd0);

        // Starvation: both held; 4 data acks, then one fetch, then data again.
        d_req = 1'b1; d_addr = 32'h0000_0100; if_req = 1'b1; if_addr = 32'h0000_0600;
        m_rdata = 32'h5555_6666;
        n_d_before_if = 0; seen_if = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk($sformatf("starve_c%0d_d_ack", c), {31'd0, d_ack},
                {31'd0, (c == 2 || c == 5 || c == 8 || c == 11 || c == 15)});
            chk($sformatf("starve_c%0d_if_ack", c), {31'd0, if_ack}, {31'd0, (c == 13)});
            if (if_ack) seen_if = 1'b1;
            if (d_ack && !seen_if) n_d_before_if++;
            if (c == 13) if_req = 1'b0;
            if (c == 15) d_req = 1'b0;
        end
        chk("starve_data_acks_before_fetch", 32'(n_d_before_if), 32'd4);

        // Misaligned word and halfword: error ack, no memory request.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1002; d_wstrb = 4'b1111;
        step();
        chk("mis_w_ack_err", {30'd0, d_ack, d_err}, 32'd3);
        chk("mis_w_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mis_w_rdata_hold", d_rdata, 32'h5555_6666);
        d_req = 1'b0;
        step();
        chk("mis_w_c2", {30'd0, d_ack, m_valid}, 32'd0);
        d_req = 1'b1; d_addr = 32'h0000_2001; d_wstrb = 4'b1100;
        step();
        chk("mis_h_ack_err", {30'd0, d_ack, d_err}, 32'd3);
        chk("mis_h_m_valid", {31'd0, m_valid}, 32'd0);
        d_req = 1'b0;
        step();

        // Fetch timeout after 8 stalled cycles, rdata forced to zero.
        if_req = 1'b1; if_addr = 32'h0000_0300; m_ready = 1'b0; m_rdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("tmo_c%0d_m_valid", c), {30'd0, m_valid, if_ack}, 32'd2);
        end
        step();
        chk("tmo_end_m_valid", {31'd0, m_valid}, 32'd0);
        chk("tmo_if_ack_err", {30'd0, if_ack, if_err}, 32'd3);
        chk("tmo_if_rdata", if_rdata, 32'd0);
        if_req = 1'b0;
        step();

        // Memory error propagates to the fetch completion.
        if_req = 1'b1; if_addr = 32'h0000_0304; m_ready = 1'b1; m_err = 1'b1;
        m_rdata = 32'h0BAD_0BAD;
        step();
        step();
        chk("merr_if_ack_err", {30'd0, if_ack, if_err}, 32'd3);
        chk("merr_if_rdata", if_rdata, 32'h0BAD_0BAD);
        if_req = 1'b0; m_err = 1'b0;
        step();

        // Write with 3 wait cycles: request fields stable for 4 m_valid cycles.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF; m_ready = 1'b0; m_rdata = 32'h1234_5678;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("wr_c%0d_valid_we_ack", c), {29'd0, m_valid, m_we, d_ack}, 32'd6);
            chk($sformatf("wr_c%0d_m_addr", c), m_addr, 32'h0000_0040);
            chk($sformatf("wr_c%0d_m_wdata", c), m_wdata, 32'hDEAD_BEEF);
            chk($sformatf("wr_c%0d_m_wstrb", c), {28'd0, m_wstrb}, 32'hF);
            if (c == 4) m_ready = 1'b1;
        end
        step();
        chk("wr_d_ack_err", {30'd0, d_ack, d_err}, 32'd2);
        chk("wr_m_valid_low", {31'd0, m_valid}, 32'd0);
        d_req = 1'b0; m_ready = 1'b0;
        step();
        chk("wr_d_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Reset during a stalled fetch abandons it; next fetch is served.
        if_req = 1'b1; if_addr = 32'h0000_0500;
        step();
        step();
        chk("rstmid_pre_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        step();
        chk("rstmid_valid_ack", {30'd0, m_valid, if_ack}, 32'd0);
        chk("rstmid_m_addr", m_addr, 32'd0);
        chk("rstmid_rdata", if_rdata | d_rdata, 32'd0);
        rst = 1'b0; m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        step();
        chk("rstmid_next_valid", {30'd0, m_valid, if_ack}, 32'd2);
        chk("rstmid_next_addr", m_addr, 32'h0000_0500);
        step();
        chk("rstmid_next_ack", {30'd0, if_ack, if_err}, 32'd2);
        chk("rstmid_next_rdata", if_rdata, 32'hCAFE_F00D);
        if_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Protocol watch: fetch and data acks are never concurrent.
    always @(negedge clk) begin
        if (!rst && if_ack && d_ack) begin
            n_checks++;
            $error("FAIL dual_ack observed=%b%b expected=not both", if_ack, d_ack);
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles m_valid is held without m_ready before an error completion.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, giving the max consecutive data grants while fetch is pending.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  fetch read request; held until if_ack.
REQ-006 if_addr  input  32  fetch address; stable while if_req.
REQ-007 if_rdata  output  32  fetch read data; valid with if_ack.
REQ-008 if_ack / if_err  output  1 each  one-cycle fetch completion pulse / error qualifier.
REQ-009 d_req, d_we  input  1 each  data request and write select; held until d_ack.
REQ-010 d_addr, d_wdata  input  32 each  data address and write data.
REQ-011 d_wstrb  input  4  byte write enables.
REQ-012 d_rdata  output  32  data read data; valid with d_ack.
REQ-013 d_ack / d_err  output  1 each  one-cycle data completion pulse / error qualifier.
REQ-014 m_valid, m_we  output  1 each  memory-port request and write select.
REQ-015 m_addr, m_wdata  output  32 each  memory-port address and write data.
REQ-016 m_wstrb  output  4  memory-port byte enables.
REQ-017 m_ready, m_err  input  1 each  memory accept/complete and error, sampled only while m_valid.
REQ-018 m_rdata  input  32  memory read data, sampled with m_ready.

Function
REQ-019 States: IDLE, GRANT_IF, GRANT_D.
- IDLE to GRANT_D: d_req and the starvation rule does not force fetch.
- IDLE to GRANT_IF: if_req and not d_req, or fetch forced.
REQ-020 Priority:
- d_req wins over if_req.
- When starve_cnt equals STARVE_LIMIT and if_req is high, fetch SHALL win.
REQ-021 starve_cnt:
- Increments on each data grant made while if_req is high.
- Clears on any fetch grant and whenever if_req is low at a grant decision.
- Saturates at STARVE_LIMIT.
REQ-022 Grant timing:
- Grant is decided in IDLE at edge N.
- m_valid and m_addr/m_we/m_wdata/m_wstrb SHALL be registered and high from cycle N+1.
- These outputs SHALL remain stable until the completing edge.
REQ-023 Fetch grant drives m_we=0 and m_wstrb=0; m_wdata don't-care.
REQ-024 Completion: at an edge with m_valid and m_ready high:
- Capture m_rdata into the granted requester's rdata.
- Pulse that requester's ack for exactly one cycle (err = m_err).
- Deassert m_valid and return to IDLE.
REQ-025 The cycle carrying ack is an IDLE cycle; re-arbitration happens at its edge, so the minimum m_valid gap between transactions is one cycle.
REQ-026 A requester's own req SHALL be ignored in the ack cycle (req still high there), so no double grant occurs.
REQ-027 Misaligned data access SHALL complete one cycle after grant with d_ack=1, d_err=1 and no m_valid:
- d_wstrb in {1111} with d_addr[1:0]!=0, or
- d_wstrb in {0011,1100} with d_addr[0]!=0.
REQ-028 Timeout:
- wait_cnt counts cycles with m_valid high and m_ready low.
- On reaching TIMEOUT_CYCLES, SHALL deassert m_valid and pulse ack+err.
- rdata = 0 on timeout.
REQ-029 if_rdata and d_rdata SHALL hold their last captured value between acks.
REQ-030 if_ack and d_ack SHALL never be high in the same cycle; at most one transaction is outstanding.

Reset
REQ-031 On rst:
- State=IDLE.
- m_valid, m_we, if_ack, if_err, d_ack, d_err = 0.
- m_addr, m_wdata, m_wstrb, if_rdata, d_rdata = 0.
- starve_cnt = wait_cnt = 0.
REQ-032 rst asserted mid-transaction SHALL abandon it with no ack pulse; m_valid is low in the cycle after the reset edge.

Structure
REQ-033 Shared package holds the state enum (IDLE/GRANT_IF/GRANT_D), the STARVE_LIMIT/TIMEOUT_CYCLES defaults, and the alignment-check function.
REQ-034 One sub-module, arb_timeout_counter (enable, clear, limit, expired), SHALL implement wait_cnt.

Verification
REQ-035 Simultaneous if_req and d_req at cycle 0, m_ready always 1 -> data granted first: m_valid at cycle 1, d_ack at cycle 2; fetch m_valid at cycle 3.
REQ-036 d_req held continuously and if_req held, STARVE_LIMIT=4 -> exactly 4 data acks, then one if_ack, then data resumes.
REQ-037 d_req, d_wstrb=1111, d_addr=0x1002 -> d_ack=1, d_err=1 one cycle after grant, m_valid never asserted.
REQ-038 if_req, m_ready held 0, TIMEOUT_CYCLES=8 -> m_valid high 8 cycles, then if_ack=1, if_err=1, if_rdata=0.
REQ-039 d_req write 0xDEADBEEF at 0x40, m_ready after 3 wait cycles -> m_addr/m_wdata/m_wstrb stable for all 4 m_valid cycles, d_ack once.
REQ-040 rst pulsed during the wait state of a fetch -> no if_ack, all outputs 0, the next request is served normally.
